sd_sdp_rx: RTL and testbench
============================

# sd_sdp_rx

Receive-side parser for slave data packets. It consumes the byte stream delivered by the line decoder and recovers the packet fields: the marker, the status byte, the two-byte length N1:N2, and the payload. It presents the latched status and the payload bytes to the master-side logic, and flags the end of each message and any framing errors. It sits between the code decoder output and the master control/host buffer logic.

## Interface
Parameters:
- MAX_LEN, 16'd512, largest accepted payload length in bytes
- TIMEOUT_CYCLES, 16'd1000, maximum allowed clk cycles between consecutive bytes of one message

Ports:
- clk  in  1  system clock. One clock; all logic is on the rising edge.
- n_rst  in  1  reset, asynchronous, active-low
- d  in  8  received byte from the decoder
- d_rdy  in  1  one-cycle strobe; `d` is valid while it is high
- rx_err  in  1  one-cycle strobe; the decoder detected a line or code error
- st_rx_err  out  1  latched status bit 0 (the slave saw an rx error)
- st_tx_rdy  out  1  latched status bit 1
- st_busy  out  1  latched status bit 2
- st_pl  out  1  latched status bit 4 (the message carries a payload)
- st_vld  out  1  one-cycle pulse: status and `len` have just been updated
- len  out  16  latched {N1, N2}
- pl_d  out  8  payload byte
- pl_rdy  out  1  one-cycle strobe; `pl_d` is valid while it is high
- msg_end  out  1  one-cycle pulse: a message completed without error
- msg_err  out  1  one-cycle pulse: the message was aborted
- err_code  out  2  cause of the abort, valid with `msg_err`: 1 = line error, 2 = bad length, 3 = timeout
- busy  out  1  high while the parser is in any state other than IDLE

## Operation
- States: IDLE, STATUS, N1, N2, PAYLOAD.
- IDLE
  - A byte with `d_rdy` and d == `MARKER_SLAVE` moves the parser to STATUS.
  - Any other byte is discarded silently; no error is raised.
- STATUS: the byte is held internally; the parser moves to N1.
- N1: the byte is held as len[15:8]; the parser moves to N2.
- N2: the byte is held as len[7:0].
  - `st_*`, `len` and `st_vld` all update together on this byte.
  - Status bit 4 = 0: `msg_end` pulses and the parser returns to IDLE. `len` is ignored.
  - Status bit 4 = 1 and 1 ≤ len ≤ MAX_LEN: the parser moves to PAYLOAD and loads the payload counter with `len`.
  - Status bit 4 = 1 and (len == 0 or len > MAX_LEN): `msg_err` pulses with err_code = 2 and the parser returns to IDLE.
- PAYLOAD
  - Each `d_rdy` forwards the byte on `pl_d` with `pl_rdy` and decrements the 16-bit counter.
  - The byte that brings the counter to 0 also pulses `msg_end`, and the parser returns to IDLE.
- `rx_err` in any state other than IDLE: abort with err_code = 1 and return to IDLE.
- `rx_err` in IDLE: ignored.
- `rx_err` and `d_rdy` in the same cycle: `rx_err` wins and the byte is discarded.
- On abort, the latched `st_*` and `len` keep their last values. Payload bytes already forwarded are not retracted.
- Status bits 3, 5, 6 and 7 are ignored.

## Timing
- All outputs are registered.
- `st_vld`, `pl_rdy`, `pl_d`, `msg_end` and `msg_err` assert exactly 1 cycle after the `d_rdy` (or `rx_err`) that causes them.
- `d_rdy` may be high on consecutive cycles. Full rate is one byte per clk with no stalls; there is no backpressure.
- For a no-payload message, `msg_end` and `st_vld` assert in the same cycle.
- For a payload message, `msg_end` asserts in the same cycle as the last `pl_rdy`.
- A marker byte arriving in the cycle after `msg_end` is accepted; the return to IDLE costs zero bubble cycles.
- `busy` is 1 from the cycle after the marker until the cycle of `msg_end` or `msg_err`, inclusive of the transition.
- Reset values:
  - all outputs 0
  - `len` = 16'h0000
  - state IDLE
  - counters 0
- Reset asserted mid-message discards the message. No `msg_end` or `msg_err` pulse is produced for it.

## Configuration
- `SDP_RX_TIMEOUT_EN` defined: a 16-bit gap counter runs in every state except IDLE.
  - The counter clears on each `d_rdy`.
  - When it reaches TIMEOUT_CYCLES without a byte, `msg_err` pulses with err_code = 3 and the parser returns to IDLE.
- `SDP_RX_TIMEOUT_EN` undefined: the gap counter is removed. The parser waits in any state indefinitely, and err_code = 3 never occurs.

## Test plan
- No-payload message: bytes {MARKER_SLAVE, 8'h06, 8'h00, 8'h00} on back-to-back cycles -> one cycle after the last byte, `st_vld`=1, `msg_end`=1, `st_tx_rdy`=1, `st_busy`=1, `st_pl`=0, `pl_rdy` never asserted.
- Payload message: {MARKER_SLAVE, 8'h10, 8'h00, 8'h03, A5, 5A, FF} -> `len`=3; `pl_rdy` 3 times carrying A5, 5A, FF; `msg_end` with the FF.
- Garbage then message: {8'h00, 8'h13, MARKER_SLAVE, 8'h00, 8'h00, 8'h00} -> the first two bytes are ignored, then one `msg_end`, and `msg_err` is never asserted.
- Bad length: MAX_LEN=512, status 8'h10 with N1:N2 = 16'h0201 -> `msg_err`, err_code=2, no `pl_rdy`, `busy`=0 afterwards.
- Line error: `rx_err` together with the second payload byte of a 4-byte message -> that byte is not forwarded, `msg_err` with err_code=1, and the next marker is accepted normally.
- Timeout (`SDP_RX_TIMEOUT_EN`, TIMEOUT_CYCLES=10): marker, then 10 idle cycles -> `msg_err` with err_code=3. The same stimulus with the macro undefined -> no error, and `busy` stays 1.

Source files
------------

// File: rtl/sd_sdp_rx.sv
// sd_sdp_rx: slave data packet receive parser (optional inter-byte timeout via SDP_RX_TIMEOUT_EN)
module sd_sdp_rx #(
  parameter logic [15:0] MAX_LEN        = 16'd512,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000,
  parameter logic [7:0]  MARKER_SLAVE   = 8'hAA
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  d,
  input  logic        d_rdy,
  input  logic        rx_err,
  output logic        st_rx_err,
  output logic        st_tx_rdy,
  output logic        st_busy,
  output logic        st_pl,
  output logic        st_vld,
  output logic [15:0] len,
  output logic [7:0]  pl_d,
  output logic        pl_rdy,
  output logic        msg_end,
  output logic        msg_err,
  output logic [1:0]  err_code,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, STATUS, N1, N2, PAYLOAD} state_t;
  state_t      state;
  logic [3:0]  st_h;
  logic [7:0]  n1;
  logic [15:0] cnt;
  logic [15:0] n_len;
  logic        len_bad;
  logic        tmo;
  assign n_len   = {n1, d};
  assign len_bad = (n_len == 16'd0) || (n_len > MAX_LEN);
`ifdef SDP_RX_TIMEOUT_EN
  logic [15:0] gap;
  assign tmo = (state != IDLE) && !d_rdy && (gap == TIMEOUT_CYCLES - 16'd1);
  // gap counter: cycles since the last byte while inside a message
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) gap <= '0;
    else gap <= (state == IDLE || d_rdy || tmo) ? 16'd0 : gap + 16'd1;
`else
  logic unused_tmo;
  assign tmo        = 1'b0;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif
  // parser FSM with registered outputs; rx_err beats timeout beats data
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state     <= IDLE;
      st_h      <= '0;
      n1        <= '0;
      cnt       <= '0;
      st_rx_err <= 1'b0;
      st_tx_rdy <= 1'b0;
      st_busy   <= 1'b0;
      st_pl     <= 1'b0;
      st_vld    <= 1'b0;
      len       <= '0;
      pl_d      <= '0;
      pl_rdy    <= 1'b0;
      msg_end   <= 1'b0;
      msg_err   <= 1'b0;
      err_code  <= '0;
      busy      <= 1'b0;
    end else begin
      st_vld  <= 1'b0;
      pl_rdy  <= 1'b0;
      msg_end <= 1'b0;
      msg_err <= 1'b0;
      if (state != IDLE && (rx_err || tmo)) begin
        state    <= IDLE;
        busy     <= 1'b0;
        msg_err  <= 1'b1;
        err_code <= rx_err ? 2'd1 : 2'd3;
      end else if (d_rdy) begin
        case (state)
          IDLE: if (d == MARKER_SLAVE) begin
            state <= STATUS;
            busy  <= 1'b1;
          end
          STATUS: begin
            st_h  <= {d[4], d[2:0]};
            state <= N1;
          end
          N1: begin
            n1    <= d;
            state <= N2;
          end
          N2: begin
            len       <= n_len;
            st_rx_err <= st_h[0];
            st_tx_rdy <= st_h[1];
            st_busy   <= st_h[2];
            st_pl     <= st_h[3];
            st_vld    <= 1'b1;
            if (st_h[3] && !len_bad) begin
              cnt   <= n_len;
              state <= PAYLOAD;
            end else begin
              state    <= IDLE;
              busy     <= 1'b0;
              msg_end  <= !st_h[3];
              msg_err  <= st_h[3];
              err_code <= st_h[3] ? 2'd2 : err_code;
            end
          end
          PAYLOAD: begin
            pl_d   <= d;
            pl_rdy <= 1'b1;
            cnt    <= cnt - 16'd1;
            if (cnt == 16'd1) begin
              msg_end <= 1'b1;
              state   <= IDLE;
              busy    <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
endmodule

// File: tb/tb_sd_sdp_rx.sv
// tb_sd_sdp_rx: directed scoreboard bench for sd_sdp_rx
module tb_sd_sdp_rx;
  localparam logic [7:0] MK = 8'hAA;
  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [7:0]  d = '0;
  logic        d_rdy = 1'b0;
  logic        rx_err = 1'b0;
  logic        st_rx_err, st_tx_rdy, st_busy, st_pl, st_vld;
  logic [15:0] len;
  logic [7:0]  pl_d;
  logic        pl_rdy, msg_end, msg_err, busy;
  logic [1:0]  err_code;
  int checks = 0;
  int failures = 0;
  logic [19:0] exp_st[$];
  logic [7:0]  exp_pl[$];
  logic [1:0]  exp_ev[$];
  logic [19:0] e_st;
  logic [7:0]  e_pl;
  logic [1:0]  e_ev;

  sd_sdp_rx #(.MAX_LEN(16'd512), .TIMEOUT_CYCLES(16'd10), .MARKER_SLAVE(MK)) dut (
    .clk(clk), .n_rst(n_rst), .d(d), .d_rdy(d_rdy), .rx_err(rx_err),
    .st_rx_err(st_rx_err), .st_tx_rdy(st_tx_rdy), .st_busy(st_busy), .st_pl(st_pl),
    .st_vld(st_vld), .len(len), .pl_d(pl_d), .pl_rdy(pl_rdy), .msg_end(msg_end),
    .msg_err(msg_err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [7:0] b, input logic v, input logic e);
    d = b;
    d_rdy = v;
    rx_err = e;
    @(posedge clk);
    #1;
    d_rdy = 1'b0;
    rx_err = 1'b0;
  endtask

  task automatic byte_in(input logic [7:0] b);
    cyc(b, 1'b1, 1'b0);
  endtask

  always @(negedge clk) if (n_rst) begin
    if (st_vld) begin
      chk("st_vld_expected", 32'(exp_st.size() != 0), 32'd1);
      if (exp_st.size() != 0) begin
        e_st = exp_st.pop_front();
        chk("status_len", 32'({st_pl, st_busy, st_tx_rdy, st_rx_err, len}), 32'(e_st));
      end
    end
    if (pl_rdy) begin
      chk("pl_rdy_expected", 32'(exp_pl.size() != 0), 32'd1);
      if (exp_pl.size() != 0) begin
        e_pl = exp_pl.pop_front();
        chk("pl_d", 32'(pl_d), 32'(e_pl));
      end
    end
    if (msg_end || msg_err) begin
      chk("end_err_exclusive", 32'(msg_end && msg_err), 32'd0);
      chk("event_expected", 32'(exp_ev.size() != 0), 32'd1);
      if (exp_ev.size() != 0) begin
        e_ev = exp_ev.pop_front();
        chk("event_code", 32'(msg_end ? 2'd0 : err_code), 32'(e_ev));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({st_rx_err, st_tx_rdy, st_busy, st_pl, st_vld, pl_rdy, msg_end, msg_err, busy, err_code}), 32'd0);
    chk("reset_len", 32'(len), 32'd0);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    // no-payload message
    byte_in(MK);
    chk("busy_after_marker", 32'(busy), 32'd1);
    byte_in(8'h06);
    byte_in(8'h00);
    exp_st.push_back({4'b0110, 16'h0000});
    exp_ev.push_back(2'd0);
    byte_in(8'h00);
    chk("nopl_vld_end_same", 32'({st_vld, msg_end, pl_rdy}), 32'b110);
    // payload message, followed immediately by next marker
    byte_in(MK);
    byte_in(8'h10);
    byte_in(8'h00);
    exp_st.push_back({4'b1000, 16'h0003});
    byte_in(8'h03);
    exp_pl.push_back(8'hA5);
    byte_in(8'hA5);
    exp_pl.push_back(8'h5A);
    byte_in(8'h5A);
    exp_pl.push_back(8'hFF);
    exp_ev.push_back(2'd0);
    byte_in(8'hFF);
    chk("last_pl_with_end", 32'({pl_rdy, msg_end, pl_d}), 32'({2'b11, 8'hFF}));
    // garbage then message, marker directly after msg_end
    byte_in(8'h00);
    byte_in(8'h13);
    byte_in(MK);
    byte_in(8'h00);
    byte_in(8'h00);
    exp_st.push_back({4'b0000, 16'h0000});
    exp_ev.push_back(2'd0);
    byte_in(8'h00);
    // bad length 0x0201 > MAX_LEN
    byte_in(MK);
    byte_in(8'h10);
    byte_in(8'h02);
    exp_st.push_back({4'b1000, 16'h0201});
    exp_ev.push_back(2'd2);
    byte_in(8'h01);
    chk("badlen_err", 32'({msg_err, err_code}), 32'b110);
    @(posedge clk);
    #1;
    chk("badlen_busy_after", 32'(busy), 32'd0);
    // zero length with payload flag
    byte_in(MK);
    byte_in(8'h10);
    byte_in(8'h00);
    exp_st.push_back({4'b1000, 16'h0000});
    exp_ev.push_back(2'd2);
    byte_in(8'h00);
    // all status bits set, length 1, ignored bits have no effect
    byte_in(MK);
    byte_in(8'hFF);
    byte_in(8'h00);
    exp_st.push_back({4'b1111, 16'h0001});
    byte_in(8'h01);
    exp_pl.push_back(8'h3C);
    exp_ev.push_back(2'd0);
    byte_in(8'h3C);
    // line error on second payload byte of 4
    byte_in(MK);
    byte_in(8'h10);
    byte_in(8'h00);
    exp_st.push_back({4'b1000, 16'h0004});
    byte_in(8'h04);
    exp_pl.push_back(8'hB0);
    byte_in(8'hB0);
    exp_ev.push_back(2'd1);
    cyc(8'hB1, 1'b1, 1'b1);
    chk("rxerr_no_fwd", 32'({pl_rdy, msg_err, err_code}), 32'b0101);
    cyc(8'h00, 1'b0, 1'b1);
    chk("rxerr_idle_ignored", 32'({msg_err, busy}), 32'd0);
    byte_in(MK);
    byte_in(8'h04);
    byte_in(8'h00);
    exp_st.push_back({4'b0100, 16'h0000});
    exp_ev.push_back(2'd0);
    byte_in(8'h00);
    // reset mid-message discards it
    byte_in(MK);
    byte_in(8'h10);
    byte_in(8'h00);
    exp_st.push_back({4'b1000, 16'h0005});
    byte_in(8'h05);
    exp_pl.push_back(8'h11);
    byte_in(8'h11);
    @(negedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    chk("midreset_clear", 32'({busy, pl_rdy, msg_end, msg_err, st_pl}), 32'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    // inter-byte gap
    byte_in(MK);
`ifdef SDP_RX_TIMEOUT_EN
    exp_ev.push_back(2'd3);
    repeat (5) @(posedge clk);
    #1;
    chk("timeout_not_early", 32'(exp_ev.size()), 32'd1);
    for (int i = 0; i < 30 && exp_ev.size() != 0; i++) @(posedge clk);
    #1;
    chk("timeout_seen", 32'(exp_ev.size()), 32'd0);
    chk("timeout_busy_after", 32'(busy), 32'd0);
`else
    repeat (30) @(posedge clk);
    #1;
    chk("no_timeout_busy", 32'(busy), 32'd1);
    exp_ev.push_back(2'd1);
    cyc(8'h00, 1'b0, 1'b1);
    chk("abort_after_wait", 32'({msg_err, err_code}), 32'b101);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("queues_drained", 32'(exp_st.size() + exp_pl.size() + exp_ev.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
